alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Sole owner of the combinational alu: accepts one operation request, drives alu
//  inputs over one or more passes, and captures the result and flags. Passes:
//  8-bit op, 16-bit indexed-address add (base + index), optional BCD adjust.
//  Returns result and flags via valid/ready. Sits between the decode/control FSM and alu.
// PARAMETERS
//  CTRL_WIDTH  4   width of alu_control / req_op (codes from params.vh)
//  DATA_WIDTH  8   alu operand width; wide requests are 2*DATA_WIDTH
// PORTS
//  clk            in   1   system clock, rising edge
//  resetn         in   1   asynchronous active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   sequencer idle, request accepted when both high
//  req_op         in   4   alu op code (params.vh: ADD, SUB, ...)
//  req_a          in   16  operand A; [15:8] used only when req_wide=1
//  req_b          in   8   operand B / index
//  req_carry      in   1   carry in
//  req_wide       in   1   16-bit address add: req_a + zero-extended req_b
//  req_decimal    in   1   BCD mode (effective only with ALU_SEQ_DECIMAL_EN)
//  rsp_valid      out  1   result available, held until rsp_ready
//  rsp_ready      in   1   consumer accepts result
//  rsp_y          out  16  result; [15:8]=0 for narrow ops
//  rsp_carry      out  1   carry out (narrow: LO/BCD pass; wide: HI pass)
//  rsp_overflow   out  1   V from LO pass (narrow); 0 for wide
//  rsp_zero       out  1   result==0 (8-bit narrow, 16-bit wide)
//  rsp_negative   out  1   rsp_y[7] narrow, rsp_y[15] wide
//  rsp_page_cross out  1   wide only: carry out of LO pass; 0 otherwise
//  alu_control    out  4   to alu
//  alu_AI, alu_BI out  8   to alu
//  alu_carry_in   out  1   to alu
//  alu_Y          in   8   from alu
//  alu_carry_out  in   1   from alu
//  alu_overflow   in   1   from alu
// BEHAVIOUR
//  States IDLE -> LO -> [HI | BCD] -> DONE -> IDLE. One request in flight; no overlap.
//  IDLE: req_ready=1; req_valid&req_ready latches all req_* -> LO.
//  LO: alu_control=op, AI=a[7:0], BI=b, CI=carry; end of cycle capture Y/C/V.
//   wide -> HI; decimal & op in {ADD,SUB} & !wide & macro -> BCD; else -> DONE.
//  HI: control=ADD, AI=a[15:8], BI=0, CI=LO carry; capture Y/C -> DONE. Always runs (fixed latency).
//  DONE: rsp_* stable, rsp_valid=1; rsp_ready -> IDLE (req_ready high next cycle).
//  Latency (accept edge n): rsp_valid from edge n+2 narrow, n+3 wide or BCD.
//  alu_* outputs combinational from state + latched operands; IDLE/DONE drive ADD,0,0,0.
//  req_wide with req_decimal: decimal ignored. req_wide with op!=ADD: LO uses op, HI uses ADD.
//  Reset (any state, incl. mid-op): state=IDLE, req_ready=1, all rsp_*=0, operands 0; request dropped.
//  Registers only on clk rise; no combinational path req_* -> rsp_*.
// CONFIGURATION
//  ALU_SEQ_DECIMAL_EN defined: BCD pass adds correction via alu (ADD: +06 if low
//   nibble >9 or half-carry, +60 if binary >99h or C; SUB: -06/-60 on borrows);
//   rsp_carry = decimal carry; V,N,Z from adjusted result.
//  Undefined: BCD state, correction logic absent; req_decimal ignored, binary result.
// STRUCTURE
//  params.vh: alu op codes (ADD, SUB, ...) and BCD correction constants (8'h06, 8'h60).
//  Sequencer state encoding local to this module.
//  Sub-module alu_bcd_fix (combinational: nibbles, half-carry -> correction, carry),
//   instantiated only under ALU_SEQ_DECIMAL_EN.
// TESTING
//  1 narrow ADD 50h+50h C=0 -> y=00A0h V=1 C=0 N=1 Z=0, rsp_valid at n+2.
//  2 narrow ADD FFh+00h C=1 -> y=0000h C=1 Z=1 V=0 page_cross=0.
//  3 wide ADD a=12F0h b=20h -> y=1310h page_cross=1 C=0; a=FFF0h b=10h -> 0000h C=1 Z=1; rsp at n+3.
//  4 rsp_ready low 5 cycles -> rsp_* stable, req_ready=0, pending req_valid not accepted.
//  5 decimal ADD 19h+28h -> 47h C=0; 99h+01h -> 00h C=1 Z=1 (macro on); macro off -> 41h, 9Ah.
//  6 resetn low during HI -> all outputs at reset values, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared ALU op codes and BCD correction constants for alu_sequencer and its helpers.
// The op code values must match the external alu's decode.
package alu_sequencer_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;

    localparam logic [7:0] BCD_FIX_LO = 8'h06;
    localparam logic [7:0] BCD_FIX_HI = 8'h60;

endpackage

// File: rtl/alu_sequencer_bcd_fix.sv
// Decimal-adjust helper for alu_sequencer: from the binary pass result, its carry and the
// nibble half-carry, it produces the correction byte and the decimal carry.
module alu_bcd_fix
    import alu_sequencer_pkg::*;
(
    input  logic [7:0] i_y,
    input  logic       i_half_carry,
    input  logic       i_carry,
    input  logic       i_sub,
    output logic [7:0] o_corr,
    output logic       o_carry
);

    logic w_fix_lo;
    logic w_fix_hi;

    // Subtraction uses not-borrow carries, so a clear carry means a borrow occurred.
    always_comb begin
        if (i_sub) begin
            w_fix_lo = ~i_half_carry;
            w_fix_hi = ~i_carry;
            o_carry  = i_carry;
        end else begin
            w_fix_lo = (i_y[3:0] > 4'd9) | i_half_carry;
            w_fix_hi = i_carry | (i_y > 8'h99);
            o_carry  = w_fix_hi;
        end
    end

    assign o_corr = (w_fix_lo ? BCD_FIX_LO : 8'h00) | (w_fix_hi ? BCD_FIX_HI : 8'h00);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-pass sequencer owning the external combinational alu: narrow op, wide indexed add,
// and (with ALU_SEQ_DECIMAL_EN defined) a BCD adjust pass.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int CTRL_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [CTRL_WIDTH-1:0]   req_op,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0]   req_b,
    input  logic                    req_carry,
    input  logic                    req_wide,
    input  logic                    req_decimal,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_y,
    output logic                    rsp_carry,
    output logic                    rsp_overflow,
    output logic                    rsp_zero,
    output logic                    rsp_negative,
    output logic                    rsp_page_cross,
    output logic [CTRL_WIDTH-1:0]   alu_control,
    output logic [DATA_WIDTH-1:0]   alu_AI,
    output logic [DATA_WIDTH-1:0]   alu_BI,
    output logic                    alu_carry_in,
    input  logic [DATA_WIDTH-1:0]   alu_Y,
    input  logic                    alu_carry_out,
    input  logic                    alu_overflow
);

    // state | meaning
    // IDLE  | ready for a request
    // LO    | low byte / narrow op on the alu
    // HI    | high byte of a wide add, carry from LO
    // BCD   | decimal correction added to the LO result
    // DONE  | response registered, then held until rsp_ready
    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
`ifdef ALU_SEQ_DECIMAL_EN
        S_BCD,
`endif
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [CTRL_WIDTH-1:0]   r_op;
    logic [2*DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic                    r_carry;
    logic                    r_wide;

    logic [DATA_WIDTH-1:0]   r_y_lo;
    logic                    r_c_lo;
    logic                    r_v_lo;
    logic [DATA_WIDTH-1:0]   r_y_hi;
    logic                    r_c_hi;

    logic                    r_rsp_valid;
    logic [2*DATA_WIDTH-1:0] r_rsp_y;
    logic                    r_rsp_c;
    logic                    r_rsp_v;
    logic                    r_rsp_z;
    logic                    r_rsp_n;
    logic                    r_rsp_pc;

`ifdef ALU_SEQ_DECIMAL_EN
    logic                    r_decimal;
    logic                    w_addsub;
    logic                    w_is_sub;
    logic                    w_half_carry;
    logic [7:0]              w_bcd_corr;
    logic                    w_bcd_carry;

    assign w_is_sub     = (r_op == CTRL_WIDTH'(OP_SUB));
    assign w_addsub     = w_is_sub || (r_op == CTRL_WIDTH'(OP_ADD));
    assign w_half_carry = r_a[4] ^ r_b[4] ^ r_y_lo[4] ^ w_is_sub;

    alu_bcd_fix u_bcd_fix (
        .i_y          (r_y_lo),
        .i_half_carry (w_half_carry),
        .i_carry      (r_c_lo),
        .i_sub        (w_is_sub),
        .o_corr       (w_bcd_corr),
        .o_carry      (w_bcd_carry)
    );
`else
    logic w_unused_decimal;
    assign w_unused_decimal = req_decimal;
`endif

    assign req_ready      = (r_state == S_IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_y          = r_rsp_y;
    assign rsp_carry      = r_rsp_c;
    assign rsp_overflow   = r_rsp_v;
    assign rsp_zero       = r_rsp_z;
    assign rsp_negative   = r_rsp_n;
    assign rsp_page_cross = r_rsp_pc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        alu_control  = CTRL_WIDTH'(OP_ADD);
        alu_AI       = '0;
        alu_BI       = '0;
        alu_carry_in = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next_state = S_LO;
            end
            S_LO: begin
                alu_control  = r_op;
                alu_AI       = r_a[DATA_WIDTH-1:0];
                alu_BI       = r_b;
                alu_carry_in = r_carry;
                if (r_wide) w_next_state = S_HI;
`ifdef ALU_SEQ_DECIMAL_EN
                else if (r_decimal && w_addsub) w_next_state = S_BCD;
`endif
                else w_next_state = S_DONE;
            end
            S_HI: begin
                alu_AI       = r_a[2*DATA_WIDTH-1:DATA_WIDTH];
                alu_carry_in = r_c_lo;
                w_next_state = S_DONE;
            end
`ifdef ALU_SEQ_DECIMAL_EN
            // The alu subtracts as AI + ~BI + CI, so CI=1 gives a plain AI - BI.
            S_BCD: begin
                alu_control  = r_op;
                alu_AI       = r_y_lo;
                alu_BI       = w_bcd_corr;
                alu_carry_in = w_is_sub;
                w_next_state = S_DONE;
            end
`endif
            S_DONE: begin
                if (r_rsp_valid && rsp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_wide      <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
            r_decimal   <= 1'b0;
`endif
            r_y_lo      <= '0;
            r_c_lo      <= 1'b0;
            r_v_lo      <= 1'b0;
            r_y_hi      <= '0;
            r_c_hi      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_c     <= 1'b0;
            r_rsp_v     <= 1'b0;
            r_rsp_z     <= 1'b0;
            r_rsp_n     <= 1'b0;
            r_rsp_pc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op      <= req_op;
                        r_a       <= req_a;
                        r_b       <= req_b;
                        r_carry   <= req_carry;
                        r_wide    <= req_wide;
`ifdef ALU_SEQ_DECIMAL_EN
                        r_decimal <= req_decimal;
`endif
                    end
                end
                S_LO: begin
                    r_y_lo <= alu_Y;
                    r_c_lo <= alu_carry_out;
                    r_v_lo <= alu_overflow;
                end
                S_HI: begin
                    r_y_hi <= alu_Y;
                    r_c_hi <= alu_carry_out;
                end
`ifdef ALU_SEQ_DECIMAL_EN
                S_BCD: begin
                    r_y_lo <= alu_Y;
                    r_c_lo <= w_bcd_carry;
                    r_v_lo <= alu_overflow;
                end
`endif
                S_DONE: begin
                    // First DONE cycle registers the response; it then holds until taken.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        if (r_wide) begin
                            r_rsp_y  <= {r_y_hi, r_y_lo};
                            r_rsp_c  <= r_c_hi;
                            r_rsp_v  <= 1'b0;
                            r_rsp_z  <= ({r_y_hi, r_y_lo} == '0);
                            r_rsp_n  <= r_y_hi[DATA_WIDTH-1];
                            r_rsp_pc <= r_c_lo;
                        end else begin
                            r_rsp_y  <= {{DATA_WIDTH{1'b0}}, r_y_lo};
                            r_rsp_c  <= r_c_lo;
                            r_rsp_v  <= r_v_lo;
                            r_rsp_z  <= (r_y_lo == '0);
                            r_rsp_n  <= r_y_lo[DATA_WIDTH-1];
                            r_rsp_pc <= 1'b0;
                        end
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: provides the combinational alu and checks directed and random
// requests against an arithmetic reference model.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    typedef struct packed {
        logic [15:0] y;
        logic        c;
        logic        v;
        logic        z;
        logic        n;
        logic        pc;
        logic        vcare;
        logic [3:0]  lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'h0;
    logic [15:0] req_a = 16'h0;
    logic [7:0]  req_b = 8'h0;
    logic        req_carry = 1'b0;
    logic        req_wide = 1'b0;
    logic        req_decimal = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_y;
    logic        rsp_carry, rsp_overflow, rsp_zero, rsp_negative, rsp_page_cross;
    logic [3:0]  alu_control;
    logic [7:0]  alu_AI, alu_BI, alu_Y;
    logic        alu_carry_in, alu_carry_out, alu_overflow;
    logic [8:0]  alu_t;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.CTRL_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_carry(req_carry),
        .req_wide(req_wide), .req_decimal(req_decimal),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .rsp_negative(rsp_negative), .rsp_page_cross(rsp_page_cross),
        .alu_control(alu_control), .alu_AI(alu_AI), .alu_BI(alu_BI),
        .alu_carry_in(alu_carry_in), .alu_Y(alu_Y),
        .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow)
    );

    always #5 clk = ~clk;

    // External alu: SUB is AI + ~BI + CI with carry meaning no-borrow.
    always_comb begin
        alu_t         = 9'd0;
        alu_Y         = 8'h00;
        alu_carry_out = 1'b0;
        alu_overflow  = 1'b0;
        case (alu_control)
            OP_ADD: begin
                alu_t         = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'd0, alu_carry_in};
                alu_Y         = alu_t[7:0];
                alu_carry_out = alu_t[8];
                alu_overflow  = (alu_AI[7] == alu_BI[7]) && (alu_t[7] != alu_AI[7]);
            end
            OP_SUB: begin
                alu_t         = {1'b0, alu_AI} + {1'b0, ~alu_BI} + {8'd0, alu_carry_in};
                alu_Y         = alu_t[7:0];
                alu_carry_out = alu_t[8];
                alu_overflow  = (alu_AI[7] != alu_BI[7]) && (alu_t[7] != alu_AI[7]);
            end
            OP_AND: alu_Y = alu_AI & alu_BI;
            OP_OR:  alu_Y = alu_AI | alu_BI;
            OP_XOR: alu_Y = alu_AI ^ alu_BI;
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int sgn8(input int x);
        return (x > 127) ? x - 256 : x;
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [7:0] b,
                                   input logic c, input logic wide, input logic dec);
        exp_t e;
        int   ai, bi, ci, s, sv, hi, da, db, d;
        logic [7:0] ly;
        logic lc, lv;
        ai = int'(a[7:0]);
        bi = int'(b);
        ci = int'(c);
        ly = 8'h00; lc = 1'b0; lv = 1'b0;
        case (op)
            OP_ADD: begin
                s  = ai + bi + ci;
                ly = 8'(s % 256);
                lc = (s > 255);
                sv = sgn8(ai) + sgn8(bi) + ci;
                lv = (sv > 127) || (sv < -128);
            end
            OP_SUB: begin
                s  = ai - bi - (1 - ci);
                ly = 8'((s + 256) % 256);
                lc = (s >= 0);
                sv = sgn8(ai) - sgn8(bi) - (1 - ci);
                lv = (sv > 127) || (sv < -128);
            end
            OP_AND: ly = a[7:0] & b;
            OP_OR:  ly = a[7:0] | b;
            OP_XOR: ly = a[7:0] ^ b;
            default: ;
        endcase
        e = '0;
        e.vcare = 1'b1;
        if (wide) begin
            hi   = int'(a[15:8]) + int'(lc);
            e.y  = {8'(hi % 256), ly};
            e.c  = (hi > 255);
            e.v  = 1'b0;
            e.pc = lc;
            e.lat = 4'd3;
        end else begin
            e.y  = {8'h00, ly};
            e.c  = lc;
            e.v  = lv;
            e.pc = 1'b0;
            e.lat = 4'd2;
`ifdef ALU_SEQ_DECIMAL_EN
            if (dec && (op == OP_ADD || op == OP_SUB)) begin
                da = 10 * int'(a[7:4]) + int'(a[3:0]);
                db = 10 * int'(b[7:4]) + int'(b[3:0]);
                if (op == OP_ADD) begin
                    d   = da + db + ci;
                    e.c = (d >= 100);
                    d   = d % 100;
                end else begin
                    d   = da - db - (1 - ci);
                    e.c = (d >= 0);
                    if (d < 0) d = d + 100;
                end
                e.y     = {8'h00, 8'((d / 10) * 16 + (d % 10))};
                e.vcare = 1'b0;
                e.lat   = 4'd3;
            end
`else
            if (dec) e.lat = 4'd2;
`endif
        end
        e.z = wide ? (e.y == 16'h0) : (e.y[7:0] == 8'h00);
        e.n = wide ? e.y[15] : e.y[7];
        return e;
    endfunction

    // Called at posedge+1 with the DUT idle; optionally stalls the response for 'hold' cycles
    // while a second request is offered.
    task automatic run_req(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [7:0] b, input logic c, input logic w, input logic d,
                           input exp_t e, input int hold);
        int cyc;
        chk({tag, ".req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        req_carry = c; req_wide = w; req_decimal = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a = 16'($urandom); req_b = 8'($urandom);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!rsp_valid && cyc < 8);
        chk({tag, ".latency"}, cyc, e.lat);
        chk({tag, ".y"}, rsp_y, e.y);
        chk({tag, ".carry"}, rsp_carry, e.c);
        if (e.vcare) chk({tag, ".overflow"}, rsp_overflow, e.v);
        chk({tag, ".zero"}, rsp_zero, e.z);
        chk({tag, ".negative"}, rsp_negative, e.n);
        chk({tag, ".page_cross"}, rsp_page_cross, e.pc);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_op = OP_XOR; req_wide = 1'b0;
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, rsp_valid, 1);
            chk({tag, ".hold_y"}, rsp_y, e.y);
            chk({tag, ".hold_carry"}, rsp_carry, e.c);
            chk({tag, ".hold_req_ready"}, req_ready, 0);
            chk({tag, ".hold_alu_ctl"}, {alu_control, alu_AI, alu_BI, alu_carry_in}, {OP_ADD, 17'h0});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"}, rsp_valid, 0);
        chk({tag, ".req_ready_back"}, req_ready, 1);
    endtask

    initial begin
        exp_t e;
        logic [3:0]  op;
        logic [15:0] a;
        logic [7:0]  b;
        logic        c, w, d;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.req_ready", req_ready, 1);
        chk("reset.rsp", {rsp_valid, rsp_y, rsp_carry, rsp_overflow, rsp_zero, rsp_negative, rsp_page_cross}, 0);
        chk("reset.alu", {alu_control, alu_AI, alu_BI, alu_carry_in}, {OP_ADD, 17'h0});
        resetn = 1'b1;
        @(posedge clk); #1;

        e = '{y:16'h00A0, c:1'b0, v:1'b1, z:1'b0, n:1'b1, pc:1'b0, vcare:1'b1, lat:4'd2};
        run_req("add50_50", OP_ADD, 16'h0050, 8'h50, 1'b0, 1'b0, 1'b0, e, 0);
        e = '{y:16'h0000, c:1'b1, v:1'b0, z:1'b1, n:1'b0, pc:1'b0, vcare:1'b1, lat:4'd2};
        run_req("addFF_00_c", OP_ADD, 16'h00FF, 8'h00, 1'b1, 1'b0, 1'b0, e, 0);
        e = '{y:16'h1310, c:1'b0, v:1'b0, z:1'b0, n:1'b0, pc:1'b1, vcare:1'b1, lat:4'd3};
        run_req("wide12F0", OP_ADD, 16'h12F0, 8'h20, 1'b0, 1'b1, 1'b0, e, 0);
        e = '{y:16'h0000, c:1'b1, v:1'b0, z:1'b1, n:1'b0, pc:1'b1, vcare:1'b1, lat:4'd3};
        run_req("wideFFF0", OP_ADD, 16'hFFF0, 8'h10, 1'b0, 1'b1, 1'b0, e, 0);
        e = '{y:16'h00F0, c:1'b0, v:1'b0, z:1'b0, n:1'b1, pc:1'b0, vcare:1'b1, lat:4'd2};
        run_req("stall", OP_OR, 16'h0030, 8'hC0, 1'b0, 1'b0, 1'b0, e, 5);

`ifdef ALU_SEQ_DECIMAL_EN
        e = '{y:16'h0047, c:1'b0, v:1'b0, z:1'b0, n:1'b0, pc:1'b0, vcare:1'b0, lat:4'd3};
        run_req("dec19_28", OP_ADD, 16'h0019, 8'h28, 1'b0, 1'b0, 1'b1, e, 0);
        e = '{y:16'h0000, c:1'b1, v:1'b0, z:1'b1, n:1'b0, pc:1'b0, vcare:1'b0, lat:4'd3};
        run_req("dec99_01", OP_ADD, 16'h0099, 8'h01, 1'b0, 1'b0, 1'b1, e, 0);
`else
        e = '{y:16'h0041, c:1'b0, v:1'b0, z:1'b0, n:1'b0, pc:1'b0, vcare:1'b1, lat:4'd2};
        run_req("dec19_28", OP_ADD, 16'h0019, 8'h28, 1'b0, 1'b0, 1'b1, e, 0);
        e = '{y:16'h009A, c:1'b0, v:1'b0, z:1'b0, n:1'b1, pc:1'b0, vcare:1'b1, lat:4'd2};
        run_req("dec99_01", OP_ADD, 16'h0099, 8'h01, 1'b0, 1'b0, 1'b1, e, 0);
`endif

        // Reset while the HI pass is on the alu.
        req_valid = 1'b1; req_op = OP_ADD; req_a = 16'h34F0; req_b = 8'h20;
        req_carry = 1'b0; req_wide = 1'b1; req_decimal = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("midreset.rsp", {rsp_valid, rsp_y, rsp_carry, rsp_overflow, rsp_zero, rsp_negative, rsp_page_cross}, 0);
        chk("midreset.req_ready", req_ready, 1);
        chk("midreset.alu", {alu_control, alu_AI, alu_BI, alu_carry_in}, {OP_ADD, 17'h0});
        #2 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("midreset.no_rsp", rsp_valid, 0);
        end
        e = model(OP_ADD, 16'h34F0, 8'h20, 1'b0, 1'b1, 1'b0);
        run_req("after_reset", OP_ADD, 16'h34F0, 8'h20, 1'b0, 1'b1, 1'b0, e, 0);

        for (int k = 0; k < 40; k++) begin
            op = 4'($urandom_range(0, 4));
            a  = 16'($urandom);
            b  = 8'($urandom);
            c  = 1'($urandom);
            w  = ($urandom_range(0, 3) == 0);
            d  = ($urandom_range(0, 2) == 0);
            if (d) begin
                a[7:0] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                b      = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            e = model(op, a, b, c, w, d);
            run_req($sformatf("rand%0d", k), op, a, b, c, w, d, e, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
